// File: rtl/rv32i_seq_ctrl_if.sv
// Handshake bundle between the RV32I sequencer, the decoder,
// the instruction/data memories and the datapath enables.
interface rv32i_seq_ctrl_if;
  logic        i_insn_vld;
  logic        i_is_load;
  logic        i_mem_wren;
  logic        i_rd_wren;
  logic        i_imem_ack;
  logic        i_dmem_ack;
  logic        o_imem_req;
  logic        o_ir_en;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        o_rd_wren;
  logic        o_pc_en;
  logic        o_retire;
  logic [31:0] o_instret;
  logic        o_trap;
  logic [1:0]  o_trap_cause;

  modport master (
    input  i_insn_vld, i_is_load, i_mem_wren, i_rd_wren,
    input  i_imem_ack, i_dmem_ack,
    output o_imem_req, o_ir_en, o_dmem_req, o_dmem_we,
    output o_rd_wren, o_pc_en, o_retire, o_instret,
    output o_trap, o_trap_cause
  );

  modport slave (
    output i_insn_vld, i_is_load, i_mem_wren, i_rd_wren,
    output i_imem_ack, i_dmem_ack,
    input  o_imem_req, o_ir_en, o_dmem_req, o_dmem_we,
    input  o_rd_wren, o_pc_en, o_retire, o_instret,
    input  o_trap, o_trap_cause
  );
endinterface

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, wait timeouts and a sticky trap state.
module rv32i_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  rv32i_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT >= (2 ** CNT_W))
  begin : g_bad_timeout
    $error("MEM_TIMEOUT out of range for CNT_W");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ld_f;
  logic             st_f;
  logic             rd_f;
  logic [31:0]      instret_q;
  logic [1:0]       cause_q;
  logic             wait_last;

  assign wait_last = (cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_FETCH;
      cnt       <= '0;
      ld_f      <= 1'b0;
      st_f      <= 1'b0;
      rd_f      <= 1'b0;
      instret_q <= '0;
      cause_q   <= 2'b00;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (bus.i_imem_ack) begin
            state <= S_DECODE;
          end else if (wait_last) begin
            state   <= S_TRAP;
            cause_q <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          ld_f <= bus.i_is_load;
          st_f <= bus.i_mem_wren;
          rd_f <= bus.i_rd_wren;
          if (!bus.i_insn_vld) begin
            state   <= S_TRAP;
            cause_q <= 2'b01;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= '0;
          if (ld_f || st_f) state <= S_MEM;
          else              state <= S_WB;
        end
        S_MEM: begin
          if (bus.i_dmem_ack) begin
            state <= S_WB;
          end else if (wait_last) begin
            state   <= S_TRAP;
            cause_q <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          instret_q <= instret_q + 32'd1;
          cnt       <= '0;
          state     <= S_FETCH;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // reset gates reqs so an aborted access drops at once
  assign bus.o_imem_req   = (state == S_FETCH) && !i_rst;
  assign bus.o_ir_en      = bus.o_imem_req && bus.i_imem_ack;
  assign bus.o_dmem_req   = (state == S_MEM) && !i_rst;
  assign bus.o_dmem_we    = bus.o_dmem_req && st_f;
  assign bus.o_pc_en      = (state == S_WB) && !i_rst;
  assign bus.o_retire     = bus.o_pc_en;
  assign bus.o_rd_wren    = bus.o_pc_en && rd_f && !st_f;
  assign bus.o_instret    = instret_q;
  assign bus.o_trap       = (state == S_TRAP);
  assign bus.o_trap_cause = cause_q;

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Randomized bench for rv32i_seq_ctrl against a per-instruction
// phase model of expected strobes, trap cause and retire count.
module tb_rv32i_seq_ctrl;

  localparam int TO = 4;

  localparam int K_ALU = 0;
  localparam int K_BR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_ILL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv32i_seq_ctrl_if bus ();

  rv32i_seq_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int nerr = 0;
  int nchk = 0;

  logic [31:0] m_cnt   = '0;
  logic [1:0]  m_cause = 2'b00;

  // {imem_req, ir_en, dmem_req, dmem_we, rd_wren, pc_en, retire, trap}
  logic [7:0] obs;
  assign obs = {bus.o_imem_req, bus.o_ir_en, bus.o_dmem_req,
                bus.o_dmem_we, bus.o_rd_wren, bus.o_pc_en,
                bus.o_retire, bus.o_trap};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_all(input string tag, input logic [7:0] exp);
    chk(tag, 32'(obs), 32'(exp));
    chk("cause", 32'(bus.o_trap_cause), 32'(m_cause));
    chk("instret", bus.o_instret, m_cnt);
  endtask

  // Called at posedge+1; drives one cycle, checks before next edge.
  task automatic cyc(input logic ia, input logic da,
                     input logic vld, input logic ld,
                     input logic st, input logic rd,
                     input logic [7:0] exp);
    bus.i_imem_ack = ia;
    bus.i_dmem_ack = da;
    bus.i_insn_vld = vld;
    bus.i_is_load  = ld;
    bus.i_mem_wren = st;
    bus.i_rd_wren  = rd;
    @(negedge clk);
    check_all("outs", exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] exp);
    cyc(rb(), rb(), rb(), rb(), rb(), rb(), exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cnt = '0;
    m_cause = 2'b00;
    bus.i_imem_ack = rb();
    bus.i_dmem_ack = rb();
    #1;
    check_all("rst_async", 8'h00);
    @(negedge clk);
    check_all("rst_hold", 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic abort_mem();
    bus.i_dmem_ack = 1'b0;
    #1;
    chk("dreq_pre_rst", 32'(bus.o_dmem_req), 32'd1);
    rst = 1'b1;
    m_cnt = '0;
    m_cause = 2'b00;
    #1;
    chk("dreq_at_rst", 32'(bus.o_dmem_req), 32'd0);
    check_all("abort", 8'h00);
    @(negedge clk);
    check_all("abort_hold", 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_insn(input int kind, input int fd,
                          input int md, input int abort_at,
                          output logic trapped);
    logic vld, ld, st, rd;
    logic [7:0] mexp;
    trapped = 1'b0;
    if (fd >= TO) begin
      for (int w = 0; w < TO; w++)
        cyc(1'b0, rb(), rb(), rb(), rb(), rb(), 8'h80);
      m_cause = 2'b10;
      trapped = 1'b1;
      return;
    end
    for (int w = 0; w <= fd; w++)
      cyc(w == fd, rb(), rb(), rb(), rb(), rb(),
          (w == fd) ? 8'hC0 : 8'h80);
    vld = (kind != K_ILL);
    ld  = (kind == K_LD);
    st  = (kind == K_ST);
    rd  = (kind == K_ALU || kind == K_LD) ? 1'b1 :
          (kind == K_BR) ? 1'b0 : rb();
    cyc(rb(), rb(), vld, ld, st, rd, 8'h00);
    if (!vld) begin
      m_cause = 2'b01;
      trapped = 1'b1;
      return;
    end
    idle(8'h00);
    if (ld || st) begin
      mexp = st ? 8'h30 : 8'h20;
      for (int w = 0; w < TO; w++) begin
        if (w == abort_at) begin
          abort_mem();
          return;
        end
        if (w > md) break;
        cyc(rb(), w == md, rb(), rb(), rb(), rb(), mexp);
      end
      if (md >= TO) begin
        m_cause = 2'b11;
        trapped = 1'b1;
        return;
      end
    end
    idle(8'h06 | ((rd && !st) ? 8'h08 : 8'h00));
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) idle(8'h01);
    do_reset();
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 11) == 0) return TO + 1;
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    logic t;
    int k;
    bus.i_imem_ack = 1'b0;
    bus.i_dmem_ack = 1'b0;
    bus.i_insn_vld = 1'b0;
    bus.i_is_load  = 1'b0;
    bus.i_mem_wren = 1'b0;
    bus.i_rd_wren  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 3; i++) run_insn(K_ALU, 0, 0, -1, t);
    chk("instret_after_3", bus.o_instret, 32'd3);

    run_insn(K_LD, 0, 3, -1, t);
    run_insn(K_ST, 0, 0, -1, t);
    run_insn(K_BR, 1, 0, -1, t);

    run_insn(K_ILL, 0, 0, -1, t);
    chk("ill_trapped", 32'(t), 32'd1);
    trap_tail();

    run_insn(K_ALU, TO, 0, -1, t);
    chk("imem_to_trapped", 32'(t), 32'd1);
    trap_tail();
    run_insn(K_ALU, TO - 1, 0, -1, t);
    chk("imem_late_ack", 32'(t), 32'd0);

    run_insn(K_ST, 0, TO, -1, t);
    chk("dmem_to_trapped", 32'(t), 32'd1);
    trap_tail();

    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    run_insn(K_ALU, 0, 0, -1, t);
    chk("instret_wrap", bus.o_instret, 32'd0);

    run_insn(K_ALU, 0, 0, -1, t);
    run_insn(K_LD, 0, 3, 1, t);
    run_insn(K_ALU, 0, 0, -1, t);

    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 19));
      k = (k == 0) ? K_ILL : (k % 4);
      run_insn(k, pick_delay(), pick_delay(), -1, t);
      if (t) trap_tail();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
